// File: rtl/jt7759_romfetch.sv
// Byte-wide ROM responder for the ADPCM controller, backed by a 16-bit external memory
// through a one-word current buffer and an optional next-word prefetch buffer.
module jt7759_romfetch #(
  parameter int             MAW      = 22,
  parameter logic [MAW-1:0] OFFSET   = '0,
  parameter bit             PREFETCH = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rom_cs,
  input  logic [16:0]    rom_addr,
  input  logic           flush,
  output logic [7:0]     rom_data,
  output logic           rom_ok,
  output logic           mem_req,
  output logic [MAW-1:0] mem_addr,
  input  logic [15:0]    mem_data,
  input  logic           mem_ok
);

  typedef enum logic [1:0] {IDLE, FETCH, PREF, DROP} state_t;

  state_t         state_q, state_d;
  logic [15:0]    cur_tag_q, cur_tag_d, cur_word_q, cur_word_d;
  logic [15:0]    nxt_tag_q, nxt_tag_d, nxt_word_q, nxt_word_d;
  logic           cur_v_q, cur_v_d, nxt_v_q, nxt_v_d;
  logic           mem_req_q, mem_req_d;
  logic [MAW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]    mem_tag_q, mem_tag_d;

  logic [15:0] req_tag;
  logic        hit, nxt_match, launch;
  logic [15:0] launch_tag;

  assign req_tag   = rom_addr[16:1];
  assign hit       = rom_cs & cur_v_q & (cur_tag_q == req_tag);
  assign nxt_match = nxt_v_q & (nxt_tag_q == req_tag);
  assign rom_ok    = hit & ~flush;
  assign rom_data  = rom_addr[0] ? cur_word_q[15:8] : cur_word_q[7:0];
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

  always_comb begin
    state_d    = state_q;
    cur_tag_d  = cur_tag_q;
    cur_word_d = cur_word_q;
    cur_v_d    = cur_v_q;
    nxt_tag_d  = nxt_tag_q;
    nxt_word_d = nxt_word_q;
    nxt_v_d    = nxt_v_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    mem_tag_d  = mem_tag_q;
    launch     = 1'b0;
    launch_tag = 16'h0;

    // A flush never aborts an external request: the in-flight word is drained and dropped.
    if (flush) begin
      cur_v_d = 1'b0;
      nxt_v_d = 1'b0;
      if (mem_req_q && !mem_ok) begin
        state_d = DROP;
      end else begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (rom_cs && !hit && nxt_match) begin
            cur_tag_d  = nxt_tag_q;
            cur_word_d = nxt_word_q;
            cur_v_d    = 1'b1;
            nxt_v_d    = 1'b0;
            if (PREFETCH && nxt_tag_q != 16'hffff) begin
              launch     = 1'b1;
              launch_tag = nxt_tag_q + 16'd1;
              state_d    = PREF;
            end
          end else if (rom_cs && !hit) begin
            launch     = 1'b1;
            launch_tag = req_tag;
            state_d    = FETCH;
          end else if (hit && PREFETCH && !nxt_v_q && cur_tag_q != 16'hffff) begin
            launch     = 1'b1;
            launch_tag = cur_tag_q + 16'd1;
            state_d    = PREF;
          end
        end
        FETCH: begin
          if (mem_ok) begin
            cur_tag_d  = mem_tag_q;
            cur_word_d = mem_data;
            cur_v_d    = 1'b1;
            mem_req_d  = 1'b0;
            state_d    = IDLE;
          end
        end
        PREF: begin
          // A request already waiting on the prefetched word takes it straight into cur.
          if (mem_ok) begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
            if (rom_cs && req_tag == mem_tag_q) begin
              cur_tag_d  = mem_tag_q;
              cur_word_d = mem_data;
              cur_v_d    = 1'b1;
            end else begin
              nxt_tag_d  = mem_tag_q;
              nxt_word_d = mem_data;
              nxt_v_d    = 1'b1;
            end
          end
        end
        DROP: begin
          if (mem_ok) begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (launch) begin
      mem_req_d  = 1'b1;
      mem_tag_d  = launch_tag;
      mem_addr_d = OFFSET + MAW'(launch_tag);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_tag_q  <= '0;
      cur_word_q <= '0;
      cur_v_q    <= 1'b0;
      nxt_tag_q  <= '0;
      nxt_word_q <= '0;
      nxt_v_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_tag_q  <= cur_tag_d;
      cur_word_q <= cur_word_d;
      cur_v_q    <= cur_v_d;
      nxt_tag_q  <= nxt_tag_d;
      nxt_word_q <= nxt_word_d;
      nxt_v_q    <= nxt_v_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_tag_q  <= mem_tag_d;
    end
  end

endmodule

// File: tb/tb_jt7759_romfetch.sv
// Directed bench for jt7759_romfetch: one instance at OFFSET 0 with an automatic memory
// responder, a second at OFFSET 22'h3F0000 driven by hand for wrap and reset cases.
module tb_jt7759_romfetch;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        rom_cs_a, flush_a, rom_ok_a, mem_req_a, mem_ok_a;
  logic [16:0] rom_addr_a;
  logic [7:0]  rom_data_a;
  logic [21:0] mem_addr_a;
  logic [15:0] mem_data_a;

  logic        rom_cs_b, flush_b, rom_ok_b, mem_req_b, mem_ok_b;
  logic [16:0] rom_addr_b;
  logic [7:0]  rom_data_b;
  logic [21:0] mem_addr_b;
  logic [15:0] mem_data_b;

  int n_checks = 0;
  int n_errors = 0;
  bit auto_a   = 1'b1;
  int cnt_a    = 0;
  localparam int LAT = 4;

  jt7759_romfetch #(.MAW(22), .OFFSET(22'h0), .PREFETCH(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rom_cs(rom_cs_a), .rom_addr(rom_addr_a), .flush(flush_a),
    .rom_data(rom_data_a), .rom_ok(rom_ok_a), .mem_req(mem_req_a), .mem_addr(mem_addr_a),
    .mem_data(mem_data_a), .mem_ok(mem_ok_a)
  );

  jt7759_romfetch #(.MAW(22), .OFFSET(22'h3F0000), .PREFETCH(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rom_cs(rom_cs_b), .rom_addr(rom_addr_b), .flush(flush_b),
    .rom_data(rom_data_b), .rom_ok(rom_ok_b), .mem_req(mem_req_b), .mem_addr(mem_addr_b),
    .mem_data(mem_data_b), .mem_ok(mem_ok_b)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [21:0] a);
    return (a == 22'd1) ? 16'hA55A : {~a[7:0], a[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock; the memory model for instance A answers LAT cycles after it sees mem_req.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_a) begin
      if (mem_ok_a) begin
        mem_ok_a = 1'b0;
        cnt_a    = 0;
      end else if (mem_req_a) begin
        cnt_a++;
        if (cnt_a == LAT) begin
          mem_ok_a   = 1'b1;
          mem_data_a = mem_word(mem_addr_a);
        end
      end else begin
        cnt_a = 0;
      end
    end
  endtask

  task automatic wait_ok_a();
    for (int i = 0; i < 20 && !mem_ok_a; i++) tick();
    check("wait_mem_ok", mem_ok_a, 1'b1);
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 20 && mem_req_a; i++) tick();
    check("wait_idle", mem_req_a, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    rom_cs_a = 0; rom_addr_a = '0; flush_a = 0; mem_ok_a = 0; mem_data_a = '0;
    rom_cs_b = 0; rom_addr_b = '0; flush_b = 0; mem_ok_b = 0; mem_data_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rom_ok", rom_ok_a, 1'b0);
    check("rst_mem_req", mem_req_a, 1'b0);
    check("rst_mem_addr", mem_addr_a, 22'h0);
    rst_n = 1'b1;
    tick();

    // Demand miss on byte 3, then an automatic prefetch of word 2
    rom_addr_a = 17'h00003; rom_cs_a = 1;
    #1 check("miss_no_ok", rom_ok_a, 1'b0);
    tick();
    check("miss_req", mem_req_a, 1'b1);
    check("miss_addr", mem_addr_a, 22'h1);
    wait_ok_a();
    check("ok_before_edge", rom_ok_a, 1'b0);
    tick();
    check("ok_after_edge", rom_ok_a, 1'b1);
    check("data_a5", rom_data_a, 8'hA5);
    tick();
    check("pref_req", mem_req_a, 1'b1);
    check("pref_addr", mem_addr_a, 22'h2);
    wait_idle_a();

    // Sequential bytes 4..7 served from promoted prefetch words
    rom_cs_a = 0; tick();
    check("no_ok_cs0", rom_ok_a, 1'b0);
    rom_addr_a = 17'h4; rom_cs_a = 1;
    #1 check("b4_pre_promo", rom_ok_a, 1'b0);
    tick();
    check("b4_ok", rom_ok_a, 1'b1);
    check("b4_data", rom_data_a, 8'h02);
    check("b4_pref_addr", mem_addr_a, 22'h3);
    rom_cs_a = 0; tick();
    rom_addr_a = 17'h5; rom_cs_a = 1;
    #1 check("b5_ok", rom_ok_a, 1'b1);
    check("b5_data", rom_data_a, 8'hFD);
    wait_idle_a();
    rom_cs_a = 0; tick();
    rom_addr_a = 17'h6; rom_cs_a = 1;
    tick();
    check("b6_ok", rom_ok_a, 1'b1);
    check("b6_data", rom_data_a, 8'h03);
    check("b6_pref_addr", mem_addr_a, 22'h4);
    rom_cs_a = 0; tick();
    rom_addr_a = 17'h7; rom_cs_a = 1;
    #1 check("b7_ok", rom_ok_a, 1'b1);
    check("b7_data", rom_data_a, 8'hFC);
    wait_idle_a();

    // Flush during a demand fetch: request held, returned word discarded
    rom_cs_a = 0; tick();
    rom_addr_a = 17'h00100; rom_cs_a = 1;
    tick();
    check("fl_req", mem_req_a, 1'b1);
    check("fl_addr", mem_addr_a, 22'h80);
    flush_a = 1; rom_cs_a = 0;
    tick();
    flush_a = 0; rom_cs_a = 1;
    check("fl_req_held", mem_req_a, 1'b1);
    check("fl_addr_held", mem_addr_a, 22'h80);
    wait_ok_a();
    tick();
    check("fl_discard_ok", rom_ok_a, 1'b0);
    check("fl_req_done", mem_req_a, 1'b0);
    rom_cs_a = 0; tick();
    rom_addr_a = 17'h00200; rom_cs_a = 1;
    tick();
    check("new_req", mem_req_a, 1'b1);
    check("new_addr", mem_addr_a, 22'h100);
    wait_ok_a();
    tick();
    check("new_ok", rom_ok_a, 1'b1);
    check("new_data", rom_data_a, 8'h00);
    tick();
    wait_idle_a();

    // Flush coinciding with mem_ok, hand-driven responses
    auto_a = 0;
    rom_cs_a = 0; tick();
    rom_addr_a = 17'h00300; rom_cs_a = 1;
    tick();
    check("co_addr", mem_addr_a, 22'h180);
    tick(); tick();
    mem_ok_a = 1; mem_data_a = 16'h1234; flush_a = 1;
    #1 check("co_flush_hit_ok", rom_ok_a, 1'b0);
    tick();
    mem_ok_a = 0; flush_a = 0;
    #1 check("co_ok", rom_ok_a, 1'b0);
    check("co_req", mem_req_a, 1'b0);
    tick();
    check("co_refetch_req", mem_req_a, 1'b1);
    check("co_refetch_addr", mem_addr_a, 22'h180);
    mem_ok_a = 1; mem_data_a = 16'hBEEF;
    tick();
    mem_ok_a = 0;
    #1 check("co_ok2", rom_ok_a, 1'b1);
    check("co_data2", rom_data_a, 8'hEF);
    auto_a = 1;
    rom_cs_a = 0; tick(); tick();
    wait_idle_a();

    // Instance B: top-of-ROM address with offset wraps to the last word, no prefetch after
    rom_addr_b = 17'h1FFFF; rom_cs_b = 1;
    tick();
    check("b_req", mem_req_b, 1'b1);
    check("b_addr", mem_addr_b, 22'h3FFFFF);
    mem_ok_b = 1; mem_data_b = 16'h7788;
    tick();
    mem_ok_b = 0;
    #1 check("b_ok", rom_ok_b, 1'b1);
    check("b_data", rom_data_b, 8'h77);
    tick(); tick();
    check("b_no_pref", mem_req_b, 1'b0);

    // Reset in the middle of a fetch on B
    rom_cs_b = 0; tick();
    rom_addr_b = 17'h00010; rom_cs_b = 1;
    tick();
    check("b2_req", mem_req_b, 1'b1);
    check("b2_addr", mem_addr_b, 22'h3F0008);
    tick();
    rst_n = 1'b0;
    #1 check("rst_mid_req", mem_req_b, 1'b0);
    check("rst_mid_ok", rom_ok_b, 1'b0);
    rom_addr_b = 17'h0;
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_refetch_req", mem_req_b, 1'b1);
    check("rst_refetch_addr", mem_addr_b, 22'h3F0000);
    rom_cs_b = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
